// File: rtl/global_counter_ctrl.sv
// rtl/global_counter_ctrl.sv - start-triggered prescaled up-counter with one-shot/auto-reload modes
//
// Purpose: on a rising edge of start (in IDLE) the block latches mode, limit
// and prescale, then counts from 1 up to the terminal value, advancing once
// every (prescale+1) clocks. In one-shot mode it pulses done and holds the
// terminal value. In auto-reload mode it pulses wrap and restarts from 1.
// A stop aborts the run silently.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   level; a synchronously detected rising edge launches a run
//   stop     in   synchronous abort, no done/wrap
//   mode     in   0 = one-shot, 1 = auto-reload (sampled on launch)
//   limit    in   terminal count, 0 selects all-ones (sampled on launch)
//   prescale in   tick divider (sampled on launch)
//   counter  out  current count value
//   busy     out  high while a run is active
//   done     out  one-cycle pulse at one-shot completion
//   wrap     out  one-cycle pulse at auto-reload
module global_counter_ctrl #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [DWIDTH-1:0] limit,
    input  logic [PWIDTH-1:0] prescale,
    output logic [DWIDTH-1:0] counter,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic              start_q,     start_d;
    logic [DWIDTH-1:0] counter_q,   counter_d;
    logic [PWIDTH-1:0] prescaler_q, prescaler_d;
    logic              mode_q,      mode_d;
    logic [DWIDTH-1:0] limit_q,     limit_d;
    logic [PWIDTH-1:0] prescale_q,  prescale_d;
    logic              done_q,      done_d;
    logic              wrap_q,      wrap_d;

    logic              start_rise;
    logic              tick;
    logic [DWIDTH-1:0] term;

    assign start_rise = start & ~start_q;
    assign tick       = (prescaler_q == prescale_q);
    // A latched limit of zero selects the full counter range.
    assign term       = (limit_q == '0) ? {DWIDTH{1'b1}} : limit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            counter_q   <= '0;
            prescaler_q <= '0;
            mode_q      <= 1'b0;
            limit_q     <= '0;
            prescale_q  <= '0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            counter_q   <= counter_d;
            prescaler_q <= prescaler_d;
            mode_q      <= mode_d;
            limit_q     <= limit_d;
            prescale_q  <= prescale_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start;
        counter_d   = counter_q;
        prescaler_d = prescaler_q;
        mode_d      = mode_q;
        limit_d     = limit_q;
        prescale_d  = prescale_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // stop on the same cycle suppresses the launch.
                if (start_rise && !stop) begin
                    state_d     = RUN;
                    counter_d   = {{(DWIDTH-1){1'b0}}, 1'b1};
                    prescaler_d = '0;
                    mode_d      = mode;
                    limit_d     = limit;
                    prescale_d  = prescale;
                end
            end
            RUN: begin
                // start edges are ignored here; stop beats any tick event.
                if (stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    prescaler_d = '0;
                    if (counter_q == term) begin
                        if (mode_q) begin
                            counter_d = {{(DWIDTH-1){1'b0}}, 1'b1};
                            wrap_d    = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        counter_d = counter_q + {{(DWIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    prescaler_d = prescaler_q + {{(PWIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign counter = counter_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_global_counter_ctrl.sv
// tb/tb_global_counter_ctrl.sv - directed self-checking bench for global_counter_ctrl
module tb_global_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] limit;
    logic [3:0] prescale;
    logic [7:0] counter;
    logic       busy;
    logic       done;
    logic       wrap;

    int pass_cnt  = 0;
    int total_cnt = 0;

    global_counter_ctrl #(.DWIDTH(8), .PWIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .limit    (limit),
        .prescale (prescale),
        .counter  (counter),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int d, input int w);
        check({tag, ".counter"}, 32'(counter), 32'(c));
        check({tag, ".busy"},    32'(busy),    32'(b));
        check({tag, ".done"},    32'(done),    32'(d));
        check({tag, ".wrap"},    32'(wrap),    32'(w));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = 8'd0; prescale = 4'd0;
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("post_reset", 0, 0, 0, 0);

        // one-shot, limit 5, no prescale
        mode = 1'b0; limit = 8'd5; prescale = 4'd0; start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk_all("oneshot_run", i, 1, 0, 0);
        end
        @(negedge clk);
        chk_all("oneshot_done", 5, 0, 1, 0);
        start = 1'b0;
        @(negedge clk);
        chk_all("oneshot_hold", 5, 0, 0, 0);

        // prescale 2, limit 3: each value held three cycles
        mode = 1'b0; limit = 8'd3; prescale = 4'd2; start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk_all("prescale_run", k / 3 + 1, 1, 0, 0);
        end
        @(negedge clk);
        chk_all("prescale_done", 3, 0, 1, 0);
        start = 1'b0;
        @(negedge clk);

        // auto-reload, limit 4, then stop
        mode = 1'b1; limit = 8'd4; prescale = 4'd0; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_all("reload_run", (i % 4) + 1, 1, 0, (i > 0 && (i % 4) == 0) ? 1 : 0);
            if (i == 2) mode = 1'b0;
        end
        stop = 1'b1;
        @(negedge clk);
        chk_all("reload_stop", 2, 0, 0, 0);
        stop = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_all("reload_frozen", 2, 0, 0, 0);

        // full range, start held high through completion
        mode = 1'b0; limit = 8'd0; prescale = 4'd0; start = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            @(negedge clk);
            check("full_counter", 32'(counter), 32'(i));
        end
        @(negedge clk);
        chk_all("full_done", 255, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk_all("full_held_start", 255, 0, 0, 0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk_all("full_relaunch", 1, 1, 0, 0);
        stop = 1'b1; start = 1'b0;
        @(negedge clk);
        chk_all("full_abort", 1, 0, 0, 0);
        stop = 1'b0;

        // stop together with start rise in IDLE: stay idle
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        chk_all("stop_blocks_start", 1, 0, 0, 0);
        start = 1'b0; stop = 1'b0;
        @(negedge clk);

        // ignored start and limit change mid-run
        mode = 1'b0; limit = 8'd10; prescale = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_all("ign_launch", 1, 1, 0, 0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk_all("ign_pre", i, 1, 0, 0);
        end
        start = 1'b1; limit = 8'd2; prescale = 4'd3; mode = 1'b1;
        for (int i = 5; i <= 10; i++) begin
            @(negedge clk);
            chk_all("ign_post", i, 1, 0, 0);
            if (i == 6) start = 1'b0;
        end
        @(negedge clk);
        chk_all("ign_done", 10, 0, 1, 0);

        // asynchronous reset mid-run
        mode = 1'b0; limit = 8'd20; prescale = 4'd0; start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk_all("areset_run", i, 1, 0, 0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk_all("areset_immediate", 0, 0, 0, 0);
        @(negedge clk);
        chk_all("areset_held", 0, 0, 0, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("areset_release", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/global_counter_ctrl.md
Name: global_counter_ctrl

Overview:
Parametrised successor to the single-shot global counter. It is a start-triggered up-counter with a programmable terminal value, a clock prescaler, and one-shot or auto-reload mode. It also provides busy/done/wrap status and a synchronous abort. It sits in the global timing path and supplies the shared count value and completion strobes to the downstream datapath and control FSMs.

Parameters:
DWIDTH, 8, width of counter, limit and count output
PWIDTH, 4, width of prescale input; counter advances once per (prescale+1) clock cycles

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level input; a rising edge, detected synchronously, launches a count run
stop  input  1  synchronous abort; ends the run with no done pulse
mode  input  1  0 = one-shot, 1 = auto-reload; sampled on launch
limit  input  DWIDTH  terminal count value; sampled on launch; 0 means all-ones
prescale  input  PWIDTH  tick divider; sampled on launch
counter  output  DWIDTH  current count value
busy  output  1  high while a run is active
done  output  1  one-cycle pulse when a one-shot run reaches its terminal count
wrap  output  1  one-cycle pulse when an auto-reload run reloads

Behaviour:
- Reset (rst_n low, asynchronous): counter=0, busy=0, done=0, wrap=0, state IDLE, start_q=0, prescaler=0, sampled mode/limit/prescale=0. Release is synchronous to clk.
- Edge detect: start_q registers start each cycle. start_rise = start & ~start_q. A start held high produces exactly one rise.
- States: IDLE, RUN. busy=1 exactly in RUN.
- IDLE + start_rise (stop low): on that edge, go to RUN, counter<=1, busy<=1, prescaler<=0. Latch mode_q/limit_q/prescale_q at the same edge. term = (limit_q==0) ? all-ones : limit_q.
- RUN tick: tick = (prescaler==prescale_q). On a tick, prescaler<=0; otherwise prescaler increments. With prescale_q=0, every cycle is a tick.
- RUN, tick, counter != term: counter <= counter+1.
- RUN, tick, counter == term, mode_q=0: go to IDLE, busy<=0, done<=1 for one cycle, counter holds term.
- RUN, tick, counter == term, mode_q=1: counter<=1, wrap<=1 for one cycle, stay in RUN.
- term==1: the first tick after launch is already terminal.
- Counter never passes term and never wraps to 0 while running.
- start_rise in RUN: ignored, with no restart and no sampling. The input is re-armed only after return to IDLE. A rise on the cycle after done is accepted.
- stop in RUN: on that edge go to IDLE, busy<=0, counter holds its current value, no done, no wrap. stop overrides a same-cycle tick or terminal event.
- stop together with start_rise in IDLE: start ignored, stay IDLE.
- stop in IDLE with no start: no effect.
- mode/limit/prescale changes during RUN: no effect until the next launch.
- done and wrap are registered outputs and are 0 in every cycle other than their event cycle.
- rst_n asserted mid-run: immediate clear to reset values. No done or wrap is emitted.
- All arithmetic is unsigned DWIDTH/PWIDTH. There is no combinational path from inputs to outputs.

Test Plan:
- Reset, then one-shot: mode=0, limit=5, prescale=0, start rise -> counter 1,2,3,4,5 on consecutive cycles. done=1 for one cycle together with busy falling after counter=5. counter holds 5.
- Prescaler: mode=0, limit=3, prescale=2 -> counter holds each value 3 cycles (1,1,1,2,2,2,3,3,3). done fires 9 cycles after launch.
- Auto-reload: mode=1, limit=4, prescale=0 -> counter 1,2,3,4,1,2... wrap pulses once per 4 cycles, busy stays 1, done stays 0. Assert stop -> busy=0 the next cycle, counter frozen, no done.
- Full range: DWIDTH=8, limit=0, mode=0 -> counter reaches 255, done pulses, counter holds 255. Start held high throughout -> no relaunch. Drop start then raise it -> new run from 1.
- Ignored start: during a limit=10 run, pulse start at counter=4 -> count continues 5..10 unaffected. Change limit to 2 mid-run -> still terminates at 10.
- Async reset: assert rst_n low mid-clock at counter=6 of a limit=20 run -> counter=0, busy=0 immediately. done and wrap never assert.
